uart_rx: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, parity and stop-bit count, framing/parity/overrun detection, and input synchronisation. Received words go into a small first-word-fall-through FIFO, which the CPU side drains with a valid/ready handshake. The block sits between the board RX pin and the CPU input bus.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_fifo.sv | 39 +++
 rtl/uart_rx.sv | 110 +++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and parity helper for the UART receiver
package uart_pkg;
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;
  localparam int MAX_DATA_BITS = 9;
  // Data is zero-extended by the caller, so unused upper bits do not affect the XOR.
  function automatic logic par_mismatch(input logic [MAX_DATA_BITS-1:0] data, input logic pbit,
                                        input parity_e mode);
    return mode == PAR_ODD ? ~(^data ^ pbit) : mode == PAR_EVEN ? (^data ^ pbit) : 1'b0;
  endfunction
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous first-word-fall-through FIFO with occupancy count
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  // Pointers carry one extra wrap bit so full and empty differ.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: parametrised UART receiver with input sync, sticky error flags and FWFT RX FIFO
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 10,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_in,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          read_int,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clear_err
);
  localparam int DW = $clog2(CLK_DIV);
  localparam parity_e PMODE = parity_e'(2'(PARITY));
  logic s1, rxs;
  state_e state;
  logic [DW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [1:0] stop_cnt;
  logic [DATA_BITS-1:0] sh;
  logic tick, last_stop, stop_tick, par_bad;
  logic push, push_ok, full, empty, fe_set, pe_set;
  assign tick      = cnt == '0;
  assign last_stop = stop_cnt == 2'(STOP_BITS-1);
  assign stop_tick = state == ST_STOP && tick;
  assign push      = stop_tick && rxs && last_stop && !par_bad;
  assign fe_set    = stop_tick && !rxs;
  assign pe_set    = stop_tick && rxs && last_stop && par_bad;
  assign push_ok   = push & (~full | (rx_valid & rx_ready));
  assign read_int  = push_ok;
  assign rx_valid  = ~empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b1;
      rxs      <= 1'b1;
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      sh       <= '0;
      par_bad  <= 1'b0;
    end else begin
      s1  <= uart_in;
      rxs <= s1;
      cnt <= tick ? DW'(CLK_DIV-1) : cnt - 1'b1;
      case (state)
        // Half-bit preload puts every later tick mid bit.
        ST_IDLE: if (!rxs) begin
          state <= ST_START;
          cnt   <= DW'(CLK_DIV/2);
        end
        ST_START: if (tick) begin
          state    <= rxs ? ST_IDLE : ST_DATA;
          bit_cnt  <= '0;
          stop_cnt <= '0;
          par_bad  <= 1'b0;
        end
        ST_DATA: if (tick) begin
          sh      <= {rxs, sh[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 4'(DATA_BITS-1)) state <= PARITY != 0 ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (tick) begin
          par_bad <= par_mismatch(MAX_DATA_BITS'(sh), rxs, PMODE);
          state   <= ST_STOP;
        end
        ST_STOP: if (tick) begin
          stop_cnt <= stop_cnt + 1'b1;
          state    <= !rxs ? ST_WAIT_IDLE : last_stop ? ST_IDLE : ST_STOP;
        end
        // A held-low break must not look like a fresh start bit.
        ST_WAIT_IDLE: if (rxs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= fe_set | (frame_err & ~clear_err);
      parity_err <= pe_set | (parity_err & ~clear_err);
      overrun    <= (push & ~push_ok) | (overrun & ~clear_err);
    end
  end
  rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (sh),
    .pop     (rx_ready),
    .rd_data (rx_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of the default receiver plus directed checks on a parity build
module tb_uart_rx;
  localparam int CLK_DIV = 10;
  localparam int DEPTH   = 4;
  typedef struct {
    int         at;
    int         kind;
    logic [7:0] w;
  } ev_t;
  logic clk = 0, rst = 1, uart_in = 1, rx_ready = 0, clear_err = 0;
  logic [7:0] rx_data;
  logic rx_valid, read_int, frame_err, parity_err, overrun;
  logic [2:0] fifo_count;
  logic uart_p = 1, rx_ready_p = 0, clear_err_p = 0;
  logic [7:0] rx_data_p;
  logic rx_valid_p, read_int_p, frame_err_p, parity_err_p, overrun_p;
  logic [2:0] fifo_count_p;
  int total = 0, bad = 0, cyc = 0, ri_cnt = 0, ri_p_cnt = 0;
  bit chk_en = 0;
  logic [7:0] q[$];
  ev_t ev[$];
  bit m_fe = 0, m_pe = 0, m_ov = 0;
  bit m_pop, m_push, m_fset, m_ovr, exp_ri;
  logic [7:0] m_w;

  uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .read_int(read_int), .fifo_count(fifo_count), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .clear_err(clear_err));

  uart_rx #(.CLK_DIV(CLK_DIV), .PARITY(1), .FIFO_DEPTH(DEPTH)) dut_p (
    .clk(clk), .rst(rst), .uart_in(uart_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .read_int(read_int_p), .fifo_count(fifo_count_p), .frame_err(frame_err_p),
    .parity_err(parity_err_p), .overrun(overrun_p), .clear_err(clear_err_p));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: a word is decided at the mid-sample of its deciding bit,
  // which is 2 sync cycles + CLK_DIV/2 + 1 + CLK_DIV per bit after the line falls.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      ev.delete();
      m_fe = 0; m_pe = 0; m_ov = 0;
    end else begin
      m_pop = q.size() > 0 && rx_ready;
      m_push = 0; m_fset = 0; m_w = 0;
      if (ev.size() > 0 && ev[0].at == cyc) begin
        m_push = ev[0].kind == 0;
        m_fset = ev[0].kind == 1;
        m_w = ev[0].w;
        void'(ev.pop_front());
      end
      m_ovr = m_push && q.size() == DEPTH && !m_pop;
      m_fe = m_fset | (m_fe & !clear_err);
      m_pe = m_pe & !clear_err;
      m_ov = m_ovr | (m_ov & !clear_err);
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_ovr) q.push_back(m_w);
    end
  end

  always @(negedge clk) if (chk_en) begin
    #1;
    exp_ri = ev.size() > 0 && ev[0].at == cyc + 1 && ev[0].kind == 0 && (q.size() < DEPTH || rx_ready);
    check("rx_valid", rx_valid, q.size() != 0);
    check("rx_data", rx_data, q.size() != 0 ? q[0] : 8'h00);
    check("fifo_count", fifo_count, q.size());
    check("read_int", read_int, exp_ri);
    check("frame_err", frame_err, m_fe);
    check("parity_err", parity_err, m_pe);
    check("overrun", overrun, m_ov);
    if (read_int) ri_cnt++;
    if (read_int_p) ri_p_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives start, 8 data bits LSB first, optional parity, one stop bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par, input bit pbit,
                            input bit stop_hi, input bit pop_at_push);
    logic [10:0] fr;
    int n, e;
    fr = has_par ? {stop_hi, pbit, d, 1'b0} : {1'b0, stop_hi, d, 1'b0};
    n = has_par ? 11 : 10;
    e = cyc + 1 + 8 + CLK_DIV * 9;
    if (!sel) ev.push_back('{at: e, kind: stop_hi ? 0 : 1, w: d});
    for (int i = 0; i < n; i++)
      for (int j = 0; j < CLK_DIV; j++) begin
        if (sel) uart_p = fr[i]; else uart_in = fr[i];
        if (pop_at_push) rx_ready = cyc == e - 1;
        @(negedge clk);
      end
    if (pop_at_push) rx_ready = 0;
  endtask

  task automatic pop_word(input logic [7:0] exp);
    @(negedge clk);
    #2;
    check("pop data", rx_data, exp);
    check("pop valid", rx_valid, 1);
    rx_ready = 1;
    @(negedge clk);
    #2;
    rx_ready = 0;
  endtask

  task automatic clear_flags;
    @(negedge clk);
    clear_err = 1;
    @(negedge clk);
    clear_err = 0;
    #2;
  endtask

  initial begin
    idle(3);
    rst = 0;
    chk_en = 1;
    #2;
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset fifo_count", fifo_count, 0);
    check("reset read_int", read_int, 0);
    check("reset flags", {frame_err, parity_err, overrun}, 0);
    // 1: single 8N1 word
    idle(3);
    ri_cnt = 0;
    send_frame(0, 8'hA5, 0, 0, 1, 0);
    #2;
    check("t1 data", rx_data, 8'hA5);
    check("t1 valid", rx_valid, 1);
    check("t1 count", fifo_count, 1);
    check("t1 read_int pulses", ri_cnt, 1);
    pop_word(8'hA5);
    check("t1 valid after pop", rx_valid, 0);
    // 2: short glitch is rejected
    idle(1);
    uart_in = 0;
    idle(4);
    uart_in = 1;
    idle(30);
    #2;
    check("t2 no push", fifo_count, 0);
    check("t2 no flags", {frame_err, parity_err, overrun}, 0);
    // 3: framing error, break held low, then a good word
    idle(1);
    send_frame(0, 8'h3C, 0, 0, 0, 0);
    idle(30);
    uart_in = 1;
    idle(30);
    send_frame(0, 8'h11, 0, 0, 1, 0);
    #2;
    check("t3 frame_err", frame_err, 1);
    check("t3 count", fifo_count, 1);
    pop_word(8'h11);
    clear_flags;
    check("t3 frame_err cleared", frame_err, 0);
    // 4: even parity on the parity build
    idle(1);
    send_frame(1, 8'h07, 1, 0, 1, 0);
    #2;
    check("t4 parity_err", parity_err_p, 1);
    check("t4 nothing pushed", rx_valid_p, 0);
    idle(1);
    send_frame(1, 8'h07, 1, 1, 1, 0);
    #2;
    check("t4 data", rx_data_p, 8'h07);
    check("t4 count", fifo_count_p, 1);
    check("t4 parity_err sticky", parity_err_p, 1);
    check("t4 read_int pulses", ri_p_cnt, 1);
    check("t4 other flags", {frame_err_p, overrun_p}, 0);
    // 5: overrun on a full FIFO, then a push rescued by a same-cycle pop
    idle(1);
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 0, 1, 0);
    #2;
    check("t5 overrun", overrun, 1);
    check("t5 count", fifo_count, 4);
    for (int i = 1; i <= 4; i++) pop_word(8'(i));
    clear_flags;
    check("t5 overrun cleared", overrun, 0);
    idle(1);
    for (int i = 1; i <= 4; i++) send_frame(0, 8'(8'h10 + i), 0, 0, 1, 0);
    send_frame(0, 8'h15, 0, 0, 1, 1);
    #2;
    check("t5 no overrun", overrun, 0);
    check("t5 count full", fifo_count, 4);
    for (int i = 2; i <= 5; i++) pop_word(8'(8'h10 + i));
    // 6: reset mid-frame with one word buffered
    idle(1);
    send_frame(0, 8'h33, 0, 0, 1, 0);
    uart_in = 0;
    idle(CLK_DIV);
    for (int i = 0; i < 3; i++) begin
      uart_in = i[0];
      idle(CLK_DIV);
    end
    rst = 1;
    uart_in = 1;
    idle(1);
    rst = 0;
    #2;
    check("t6 valid after rst", rx_valid, 0);
    check("t6 count after rst", fifo_count, 0);
    idle(20);
    send_frame(0, 8'h5A, 0, 0, 1, 0);
    #2;
    check("t6 data", rx_data, 8'h5A);
    check("t6 count", fifo_count, 1);
    idle(5);
    chk_en = 0;
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
